// File: rtl/video_pkg.sv
// Shared video types and pixel helpers: scanline modes, bit-replicating colour
// expansion and scanline attenuation.
package video_pkg;

    typedef enum logic [1:0] {
        OFF = 2'd0,
        S75 = 2'd1,
        S50 = 2'd2,
        S25 = 2'd3
    } scanline_mode_e;

    // Repeat the low `depth` bits MSB-first until 8 bits are filled.
    function automatic logic [7:0] expand8(input logic [7:0] value, input int unsigned depth);
        logic [7:0]  res;
        int unsigned src;
        res = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            src = depth - 1 - (i % depth);
            res = {res[6:0], value[src[2:0]]};
        end
        return res;
    endfunction

    function automatic logic [7:0] attenuate(input logic [7:0] v, input scanline_mode_e mode);
        logic [7:0] res;
        case (mode)
            S75:     res = v - (v >> 2);
            S50:     res = v >> 1;
            S25:     res = v >> 2;
            default: res = v;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/video_ce_div.sv
// Pixel clock-enable divider: ce_o pulses once every CE_DIV clocks, and
// ce_pixel_o is ce_o delayed one clock to mark when registered results appear.
module video_ce_div #(
    parameter int unsigned CE_DIV = 1
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic ce_o,
    output logic ce_pixel_o
);

    localparam int unsigned CntW = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            ce_dly_q;

    assign ce_o       = (cnt_q == CntW'(CE_DIV - 1));
    assign ce_pixel_o = ce_dly_q;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (ce_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q    <= '0;
            ce_dly_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            ce_dly_q <= ce_o;
        end
    end

endmodule

// File: rtl/video_out_stage.sv
// Video output stage: colour expansion, DE blanking and line-width checking over a
// two-stage ce pipeline. Scanline darkening is built only with VIDEO_SCANLINE_EN.
module video_out_stage
    import video_pkg::*;
#(
    parameter int unsigned IN_DEPTH    = 4,
    parameter int unsigned CE_DIV      = 1,
    parameter int unsigned LINE_LENGTH = 320
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [IN_DEPTH-1:0] R_IN,
    input  logic [IN_DEPTH-1:0] G_IN,
    input  logic [IN_DEPTH-1:0] B_IN,
    input  logic                HBlank,
    input  logic                VBlank,
    input  logic                HSync,
    input  logic                VSync,
    input  logic [1:0]          scanlines,
    input  logic                err_clr,
    output logic                CE_PIXEL,
    output logic [7:0]          VGA_R,
    output logic [7:0]          VGA_G,
    output logic [7:0]          VGA_B,
    output logic                VGA_HS,
    output logic                VGA_VS,
    output logic                VGA_DE,
    output logic                line_err
);

    localparam int unsigned CntW = $clog2(LINE_LENGTH + 1) + 1;

    logic ce;

    video_ce_div #(
        .CE_DIV(CE_DIV)
    ) u_ce_div (
        .clk_i     (clk),
        .rst_i     (reset),
        .ce_o      (ce),
        .ce_pixel_o(CE_PIXEL)
    );

    logic [7:0]      s1_r_q, s1_r_d, s1_g_q, s1_g_d, s1_b_q, s1_b_d;
    logic            s1_hs_q, s1_hs_d, s1_vs_q, s1_vs_d, s1_de_q, s1_de_d;
    logic [7:0]      out_r_q, out_r_d, out_g_q, out_g_d, out_b_q, out_b_d;
    logic            out_hs_q, out_hs_d, out_vs_q, out_vs_d, out_de_q, out_de_d;
    logic            hb_prev_q, hb_prev_d, vb_prev_q, vb_prev_d;
    logic [CntW-1:0] pix_cnt_q, pix_cnt_d;
    logic            err_q, err_d;
    logic            hb_rise, vb_rise, err_set;
    scanline_mode_e  mode;

`ifdef VIDEO_SCANLINE_EN
    logic par_q, par_d, hs_prev_q, vs_prev_q;
    logic hs_rise, vs_rise;

    assign hs_rise = HSync & ~hs_prev_q;
    assign vs_rise = VSync & ~vs_prev_q;

    // A VSync edge restarts the frame on an even line, even if HSync rises too.
    always_comb begin
        par_d = par_q;
        if (ce) begin
            if (vs_rise) begin
                par_d = 1'b0;
            end else if (hs_rise) begin
                par_d = ~par_q;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            par_q     <= 1'b0;
            hs_prev_q <= 1'b0;
            vs_prev_q <= 1'b0;
        end else if (ce) begin
            par_q     <= par_d;
            hs_prev_q <= HSync;
            vs_prev_q <= VSync;
        end
    end

    assign mode = par_q ? scanline_mode_e'(scanlines) : OFF;
`else
    logic unused_scanlines;
    assign unused_scanlines = ^scanlines;
    assign mode             = OFF;
`endif

    assign hb_rise = HBlank & ~hb_prev_q;
    assign vb_rise = VBlank & ~vb_prev_q;

    always_comb begin
        s1_r_d    = s1_r_q;
        s1_g_d    = s1_g_q;
        s1_b_d    = s1_b_q;
        s1_hs_d   = s1_hs_q;
        s1_vs_d   = s1_vs_q;
        s1_de_d   = s1_de_q;
        out_r_d   = out_r_q;
        out_g_d   = out_g_q;
        out_b_d   = out_b_q;
        out_hs_d  = out_hs_q;
        out_vs_d  = out_vs_q;
        out_de_d  = out_de_q;
        hb_prev_d = hb_prev_q;
        vb_prev_d = vb_prev_q;
        pix_cnt_d = pix_cnt_q;
        err_set   = 1'b0;
        if (ce) begin
            s1_r_d    = expand8(8'(R_IN), IN_DEPTH);
            s1_g_d    = expand8(8'(G_IN), IN_DEPTH);
            s1_b_d    = expand8(8'(B_IN), IN_DEPTH);
            s1_hs_d   = HSync;
            s1_vs_d   = VSync;
            s1_de_d   = ~(HBlank | VBlank);
            out_r_d   = s1_de_q ? attenuate(s1_r_q, mode) : 8'h00;
            out_g_d   = s1_de_q ? attenuate(s1_g_q, mode) : 8'h00;
            out_b_d   = s1_de_q ? attenuate(s1_b_q, mode) : 8'h00;
            out_hs_d  = s1_hs_q;
            out_vs_d  = s1_vs_q;
            out_de_d  = s1_de_q;
            hb_prev_d = HBlank;
            vb_prev_d = VBlank;
            if (hb_rise && !VBlank) begin
                err_set   = (pix_cnt_q != CntW'(LINE_LENGTH));
                pix_cnt_d = '0;
            end else if (vb_rise) begin
                pix_cnt_d = '0;
            end else if (!HBlank && !VBlank && (pix_cnt_q != '1)) begin
                pix_cnt_d = pix_cnt_q + 1'b1;
            end
        end
        // err_clr is not ce-gated; a same-cycle mismatch still wins.
        err_d = err_set ? 1'b1 : (err_clr ? 1'b0 : err_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_r_q    <= '0;
            s1_g_q    <= '0;
            s1_b_q    <= '0;
            s1_hs_q   <= 1'b0;
            s1_vs_q   <= 1'b0;
            s1_de_q   <= 1'b0;
            out_r_q   <= '0;
            out_g_q   <= '0;
            out_b_q   <= '0;
            out_hs_q  <= 1'b0;
            out_vs_q  <= 1'b0;
            out_de_q  <= 1'b0;
            hb_prev_q <= 1'b0;
            vb_prev_q <= 1'b0;
            pix_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            s1_r_q    <= s1_r_d;
            s1_g_q    <= s1_g_d;
            s1_b_q    <= s1_b_d;
            s1_hs_q   <= s1_hs_d;
            s1_vs_q   <= s1_vs_d;
            s1_de_q   <= s1_de_d;
            out_r_q   <= out_r_d;
            out_g_q   <= out_g_d;
            out_b_q   <= out_b_d;
            out_hs_q  <= out_hs_d;
            out_vs_q  <= out_vs_d;
            out_de_q  <= out_de_d;
            hb_prev_q <= hb_prev_d;
            vb_prev_q <= vb_prev_d;
            pix_cnt_q <= pix_cnt_d;
            err_q     <= err_d;
        end
    end

    assign VGA_R    = out_r_q;
    assign VGA_G    = out_g_q;
    assign VGA_B    = out_b_q;
    assign VGA_HS   = out_hs_q;
    assign VGA_VS   = out_vs_q;
    assign VGA_DE   = out_de_q;
    assign line_err = err_q;

endmodule

// File: tb/tb_video_out_stage.sv
// Bench for video_out_stage: two instances (4-bit/CE_DIV=1 and 3-bit/CE_DIV=3) on shared
// stimulus, checked every clock against a behavioural model plus directed checks.
module tb_video_out_stage;

    localparam int LL     = 320;
    localparam int CntMax = (1 << ($clog2(LL + 1) + 1)) - 1;
`ifdef VIDEO_SCANLINE_EN
    localparam bit ScanEn = 1'b1;
`else
    localparam bit ScanEn = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] r_in, g_in, b_in;
    logic       hb, vb, hs, vs, err_clr;
    logic [1:0] scan;

    logic       a_cep, a_hs, a_vs, a_de, a_err;
    logic [7:0] a_r, a_g, a_b;
    logic       b_cep, b_hs, b_vs, b_de, b_err;
    logic [7:0] b_r, b_g, b_b;

    int n_assert;
    int n_fail;

    always #5 clk = ~clk;

    video_out_stage #(.IN_DEPTH(4), .CE_DIV(1), .LINE_LENGTH(LL)) dut_a (
        .clk(clk), .reset(reset), .R_IN(r_in[3:0]), .G_IN(g_in[3:0]), .B_IN(b_in[3:0]),
        .HBlank(hb), .VBlank(vb), .HSync(hs), .VSync(vs), .scanlines(scan),
        .err_clr(err_clr), .CE_PIXEL(a_cep), .VGA_R(a_r), .VGA_G(a_g), .VGA_B(a_b),
        .VGA_HS(a_hs), .VGA_VS(a_vs), .VGA_DE(a_de), .line_err(a_err)
    );

    video_out_stage #(.IN_DEPTH(3), .CE_DIV(3), .LINE_LENGTH(LL)) dut_b (
        .clk(clk), .reset(reset), .R_IN(r_in[2:0]), .G_IN(g_in[2:0]), .B_IN(b_in[2:0]),
        .HBlank(hb), .VBlank(vb), .HSync(hs), .VSync(vs), .scanlines(scan),
        .err_clr(err_clr), .CE_PIXEL(b_cep), .VGA_R(b_r), .VGA_G(b_g), .VGA_B(b_b),
        .VGA_HS(b_hs), .VGA_VS(b_vs), .VGA_DE(b_de), .line_err(b_err)
    );

    // Reference model state: s_* is the most recent sampled pixel, o_* the visible outputs.
    typedef struct packed {
        int       n;
        int       cnt;
        bit       par, err, phs, pvs, phb, pvb;
        bit [7:0] s_r, s_g, s_b;
        bit       s_hs, s_vs, s_de, s_par;
        bit [7:0] o_r, o_g, o_b;
        bit       o_hs, o_vs, o_de, o_cep;
    } model_t;

    model_t m[2];

    function automatic int divof(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic int depthof(input int i);
        return (i == 0) ? 4 : 3;
    endfunction

    function automatic logic [7:0] ref_expand(input int unsigned v, input int unsigned d);
        int unsigned acc = 0;
        int unsigned bits = 0;
        while (bits < 8) begin
            acc  = (acc << d) | v;
            bits = bits + d;
        end
        return 8'(acc >> (bits - 8));
    endfunction

    function automatic logic [7:0] ref_att(input logic [7:0] v, input logic [1:0] s, input bit par);
        if (!ScanEn || !par) return v;
        case (s)
            2'd1:    return v - v / 4;
            2'd2:    return v / 2;
            2'd3:    return v / 4;
            default: return v;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) m[i] = '0;
    endtask

    task automatic model_clock();
        for (int i = 0; i < 2; i++) begin
            bit ce, set, hs_r, vs_r, hb_r, vb_r;
            int unsigned d;
            if (!reset) begin
                m[i].n++;
                ce          = (m[i].n % divof(i)) == 0;
                set         = 1'b0;
                m[i].o_cep  = ce;
                if (ce) begin
                    m[i].o_r  = m[i].s_de ? ref_att(m[i].s_r, scan, m[i].s_par) : 8'h00;
                    m[i].o_g  = m[i].s_de ? ref_att(m[i].s_g, scan, m[i].s_par) : 8'h00;
                    m[i].o_b  = m[i].s_de ? ref_att(m[i].s_b, scan, m[i].s_par) : 8'h00;
                    m[i].o_hs = m[i].s_hs;
                    m[i].o_vs = m[i].s_vs;
                    m[i].o_de = m[i].s_de;
                    hs_r = hs && !m[i].phs;
                    vs_r = vs && !m[i].pvs;
                    hb_r = hb && !m[i].phb;
                    vb_r = vb && !m[i].pvb;
                    if (vs_r) m[i].par = 1'b0;
                    else if (hs_r) m[i].par = !m[i].par;
                    d          = depthof(i);
                    m[i].s_r   = ref_expand(r_in % (1 << d), d);
                    m[i].s_g   = ref_expand(g_in % (1 << d), d);
                    m[i].s_b   = ref_expand(b_in % (1 << d), d);
                    m[i].s_hs  = hs;
                    m[i].s_vs  = vs;
                    m[i].s_de  = !(hb || vb);
                    m[i].s_par = m[i].par;
                    if (hb_r && !vb) begin
                        set      = (m[i].cnt != LL);
                        m[i].cnt = 0;
                    end else if (vb_r) begin
                        m[i].cnt = 0;
                    end else if (!hb && !vb && m[i].cnt < CntMax) begin
                        m[i].cnt = m[i].cnt + 1;
                    end
                    m[i].phs = hs;
                    m[i].pvs = vs;
                    m[i].phb = hb;
                    m[i].pvb = vb;
                end
                if (set) m[i].err = 1'b1;
                else if (err_clr) m[i].err = 1'b0;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("a_cep", a_cep, m[0].o_cep);
        chk("a_r", a_r, m[0].o_r);
        chk("a_g", a_g, m[0].o_g);
        chk("a_b", a_b, m[0].o_b);
        chk("a_hs", a_hs, m[0].o_hs);
        chk("a_vs", a_vs, m[0].o_vs);
        chk("a_de", a_de, m[0].o_de);
        chk("a_err", a_err, m[0].err);
        chk("b_cep", b_cep, m[1].o_cep);
        chk("b_r", b_r, m[1].o_r);
        chk("b_g", b_g, m[1].o_g);
        chk("b_b", b_b, m[1].o_b);
        chk("b_hs", b_hs, m[1].o_hs);
        chk("b_vs", b_vs, m[1].o_vs);
        chk("b_de", b_de, m[1].o_de);
        chk("b_err", b_err, m[1].err);
    endtask

    task automatic tick();
        @(posedge clk);
        model_clock();
        @(negedge clk);
        check_all();
    endtask

    task automatic ce_sequence(input int nclk);
        for (int k = 1; k <= nclk; k++) begin
            tick();
            chk("a_cep_seq", a_cep, 1);
            chk("b_cep_seq", b_cep, (k % 3) == 0);
        end
    endtask

    task automatic vblank();
        for (int k = 0; k < 8; k++) begin
            vb   = 1'b1;
            hb   = (k >= 2 && k < 5) ? 1'b0 : 1'b1;
            hs   = 1'b0;
            vs   = (k >= 1 && k <= 5);
            r_in = 8'($urandom) | 8'h01;
            g_in = 8'($urandom) | 8'h01;
            b_in = 8'($urandom) | 8'h01;
            tick();
            if (k == 6) begin
                chk("vbl_de", a_de, 0);
                chk("vbl_r", a_r, 0);
                chk("vbl_vs", a_vs, 1);
            end
        end
        vs = 1'b0;
    endtask

    // One line: 4-clock HBlank with an HSync pulse, then npix active pixels.
    task automatic line(input bit with_vs, input int npix, input logic [1:0] sm, input bit rnd,
                        input logic [7:0] val, input logic [7:0] exp_mid, input int exp_err,
                        input bit clr_rise, input bit clr_mid);
        scan = sm;
        for (int k = 0; k < 4; k++) begin
            vb      = 1'b0;
            hb      = 1'b1;
            hs      = (k == 1 || k == 2);
            vs      = with_vs && (k == 1 || k == 2);
            err_clr = clr_rise && (k == 0);
            r_in    = 8'($urandom);
            g_in    = 8'($urandom);
            b_in    = 8'($urandom);
            tick();
            if (k == 0 && exp_err >= 0) chk("line_err_at_rise", a_err, exp_err);
        end
        err_clr = 1'b0;
        hs      = 1'b0;
        vs      = 1'b0;
        for (int p = 0; p < npix; p++) begin
            hb      = 1'b0;
            r_in    = rnd ? 8'($urandom) : val;
            g_in    = rnd ? 8'($urandom) : val;
            b_in    = rnd ? 8'($urandom) : val;
            err_clr = clr_mid && (p == 20);
            tick();
            if (!rnd && p == 12) chk("line_mid_r", a_r, exp_mid);
            if (clr_mid && p == 20) chk("err_clr_alone", a_err, 0);
        end
        err_clr = 1'b0;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        reset    = 1'b1;
        hb       = 1'b1;
        vb       = 1'b1;
        hs       = 1'b0;
        vs       = 1'b0;
        r_in     = '0;
        g_in     = '0;
        b_in     = '0;
        scan     = 2'd0;
        err_clr  = 1'b0;
        model_reset();
        #1;
        check_all();
        repeat (3) tick();
        reset = 1'b0;
        ce_sequence(9);

        vblank();
        line(1'b1, LL, 2'd2, 1'b0, 8'h0F, 8'hFF, 0, 1'b0, 1'b0);
        line(1'b0, LL, 2'd2, 1'b0, 8'h0F, ScanEn ? 8'h7F : 8'hFF, 0, 1'b0, 1'b0);
        line(1'b0, LL, 2'd1, 1'b0, 8'h0F, 8'hFF, 0, 1'b0, 1'b0);
        line(1'b0, LL, 2'd1, 1'b0, 8'h0F, ScanEn ? 8'hC0 : 8'hFF, 0, 1'b0, 1'b0);
        line(1'b0, LL, 2'd3, 1'b0, 8'h0F, 8'hFF, 0, 1'b0, 1'b0);
        line(1'b0, LL, 2'd3, 1'b0, 8'h0F, ScanEn ? 8'h3F : 8'hFF, 0, 1'b0, 1'b0);
        line(1'b0, LL - 1, 2'd0, 1'b0, 8'h0F, 8'hFF, 0, 1'b0, 1'b0);
        line(1'b0, LL - 1, 2'd0, 1'b0, 8'h0F, 8'hFF, 1, 1'b0, 1'b0);
        line(1'b0, LL, 2'd0, 1'b0, 8'h0F, 8'hFF, 1, 1'b1, 1'b1);
        line(1'b0, LL, 2'd0, 1'b0, 8'h0F, 8'hFF, 0, 1'b0, 1'b0);

        // Expansion of held colours on both depths.
        scan = 2'd0;
        hb   = 1'b0;
        r_in = 8'h0A;
        repeat (3) tick();
        chk("expand_a_0xA", a_r, 8'hAA);
        r_in = 8'h05;
        repeat (9) tick();
        chk("expand_b_5", b_r, 8'hB6);
        chk("expand_a_5", a_r, 8'h55);

        vblank();
        for (int j = 0; j < 4; j++) begin
            line(1'b0, $urandom_range(LL - 2, LL + 2), 2'($urandom), 1'b1, 8'h00, 8'h00, -1,
                 1'b0, 1'b0);
        end

        // Asynchronous reset in the middle of an active line.
        reset = 1'b1;
        #1;
        model_reset();
        check_all();
        chk("mid_reset_err", a_err, 0);
        repeat (2) tick();
        reset = 1'b0;
        ce_sequence(6);
        for (int j = 0; j < 3; j++) begin
            line(1'b0, $urandom_range(LL - 1, LL + 1), 2'($urandom), 1'b1, 8'h00, 8'h00, -1,
                 1'b0, 1'b0);
        end
        line(1'b0, 0, 2'd0, 1'b1, 8'h00, 8'h00, -1, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
